// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush, bubble insertion and flush-drop accounting.
// Define PIPE_STAGE_SKID_BUF_EN to add a skid entry behind the head entry.
module pipe_stage_reg #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CTRL_W         = 24,
  parameter bit          FLUSH_DATA_CLR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [7:0]        drop_cnt
);

  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic              skid_valid_q;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic       accept;
  logic       drain;
  logic       head_free;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

`ifdef PIPE_STAGE_SKID_BUF_EN
  logic              skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  assign in_ready = !skid_valid_q && !flush && !bubble;
`else
  assign skid_valid_q = 1'b0;
  assign in_ready     = (!head_valid_q || out_ready) && !flush && !bubble;
`endif

  assign accept    = in_valid && in_ready;
  assign drain     = head_valid_q && out_ready;
  assign head_free = !head_valid_q || drain;

  // A head leaving downstream on the flush edge was delivered, not dropped.
  assign drop_inc = {1'b0, head_valid_q && !drain} + {1'b0, skid_valid_q};
  assign drop_sum = {1'b0, drop_cnt_q} + {7'd0, drop_inc};

  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_ctrl_d  = head_ctrl_q;
    drop_cnt_d   = drop_cnt_q;
`ifdef PIPE_STAGE_SKID_BUF_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
`endif
    if (flush) begin
      head_valid_d = 1'b0;
      head_ctrl_d  = '0;
      if (FLUSH_DATA_CLR) head_data_d = '0;
`ifdef PIPE_STAGE_SKID_BUF_EN
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (FLUSH_DATA_CLR) skid_data_d = '0;
`endif
      drop_cnt_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
`ifdef PIPE_STAGE_SKID_BUF_EN
    else if (drain && skid_valid_q) begin
      head_valid_d = 1'b1;
      head_data_d  = skid_data_q;
      head_ctrl_d  = skid_ctrl_q;
      skid_valid_d = 1'b0;
    end
`endif
    else if (accept) begin
      if (head_free) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
        head_ctrl_d  = in_ctrl;
      end
`ifdef PIPE_STAGE_SKID_BUF_EN
      else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_ctrl_d  = in_ctrl;
      end
`endif
    end else if (bubble && head_free && !skid_valid_q) begin
      // NOP beat: valid with zero control, payload left as it was.
      head_valid_d = 1'b1;
      head_ctrl_d  = '0;
    end else if (drain) begin
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_ctrl_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_ctrl_q  <= head_ctrl_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_BUF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`endif

  assign out_valid = head_valid_q;
  assign out_data  = head_data_q;
  assign out_ctrl  = head_ctrl_q;
  assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; adapts to PIPE_STAGE_SKID_BUF_EN.
module tb_pipe_stage_reg;

  localparam int unsigned DataW = 32;
  localparam int unsigned CtrlW = 24;
`ifdef PIPE_STAGE_SKID_BUF_EN
  localparam int unsigned Depth = 2;
`else
  localparam int unsigned Depth = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [DataW-1:0] in_data;
  logic [CtrlW-1:0] in_ctrl;
  logic             flush;
  logic             bubble;
  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] out_data;
  logic [CtrlW-1:0] out_ctrl;
  logic [1:0]       occupancy;
  logic [7:0]       drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int drop_exp = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W         (DataW),
    .CTRL_W         (CtrlW),
    .FLUSH_DATA_CLR (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .bubble    (bubble),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load n beats with downstream stalled; leaves in_valid low.
  task automatic fill(input int n, input logic [31:0] base);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 24'h00abcd;
    for (int i = 0; i < n; i++) begin
      in_data = base + 32'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] v3 [3];

  initial begin
    v3 = '{32'h11, 32'h22, 32'h33};
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Streaming with downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = v3[i];
      in_ctrl = CtrlW'(i + 1);
      #1;
      check_eq("fwd_in_ready", in_ready, 1);
      step();
      check_eq("fwd_out_valid", out_valid, 1);
      check_eq("fwd_out_data", out_data, v3[i]);
      check_eq("fwd_out_ctrl", out_ctrl, 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    check_eq("fwd_empty", out_valid, 0);

    // Backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'haa;
    step();
    in_data = 32'hbb;
`ifdef PIPE_STAGE_SKID_BUF_EN
    step();
    in_valid = 1'b0;
    #1;
    check_eq("bp_occ2", occupancy, 2);
    check_eq("bp_in_ready_full", in_ready, 0);
    check_eq("bp_head_aa", out_data, 32'haa);
    out_ready = 1'b1;
    step();
    check_eq("bp_head_bb", out_data, 32'hbb);
    check_eq("bp_valid_bb", out_valid, 1);
    check_eq("bp_in_ready_after", in_ready, 1);
    check_eq("bp_occ1", occupancy, 1);
`else
    #1;
    check_eq("bp_in_ready_held", in_ready, 0);
    check_eq("bp_occ1", occupancy, 1);
    check_eq("bp_head_aa", out_data, 32'haa);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_comb", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_bb", out_data, 32'hbb);
    check_eq("bp_occ_bb", occupancy, 1);
`endif
    step();
    check_eq("bp_drained", out_valid, 0);
    check_eq("bp_occ0", occupancy, 0);

    // Flush of a full stage.
    fill(Depth, 32'h40);
    flush = 1'b1;
    #1;
    check_eq("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    drop_exp += Depth;
    check_eq("fl_occ", occupancy, 0);
    check_eq("fl_out_valid", out_valid, 0);
    check_eq("fl_drop", drop_cnt, 32'(drop_exp));
    check_eq("fl_data_clr", out_data, 0);
    check_eq("fl_ctrl_clr", out_ctrl, 0);

    // Flush while the head drains: not counted.
    fill(1, 32'h50);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_drain_drop", drop_cnt, 32'(drop_exp));
    check_eq("fl_drain_valid", out_valid, 0);

    // Saturation.
    for (int k = 0; k < 300; k++) begin
      fill(Depth, 32'h100 + 32'(k));
      flush = 1'b1;
      step();
      flush = 1'b0;
      drop_exp = (drop_exp + Depth > 255) ? 255 : drop_exp + Depth;
    end
    check_eq("sat_drop_model", drop_cnt, 32'(drop_exp));
    check_eq("sat_drop_255", drop_cnt, 32'd255);

    // Bubble on an empty stage.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("rst2_drop_cnt", drop_cnt, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5c;
    in_ctrl   = 24'h000123;
    bubble    = 1'b1;
    #1;
    check_eq("bub_in_ready", in_ready, 0);
    step();
    bubble = 1'b0;
    check_eq("bub_valid", out_valid, 1);
    check_eq("bub_ctrl", out_ctrl, 0);
    check_eq("bub_data", out_data, 0);
    check_eq("bub_occ", occupancy, 1);
    step();
    check_eq("bub_next_data", out_data, 32'h5c);
    check_eq("bub_next_ctrl", out_ctrl, 32'h123);
    in_valid = 1'b0;
    step();
    check_eq("bub_empty", out_valid, 0);

    // Reset beats flush and accept in the same cycle.
    fill(1, 32'h77);
    check_eq("rf_occ_before", occupancy, 1);
    reset    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    step();
    check_eq("rf_out_valid", out_valid, 0);
    check_eq("rf_occ", occupancy, 0);
    check_eq("rf_drop", drop_cnt, 0);
    check_eq("rf_data", out_data, 0);
    check_eq("rf_ctrl", out_ctrl, 0);
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rf_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
